// File: rtl/bnn_param_loader_if.sv
// Host-side byte stream into the BNN parameter loader (valid/ready handshake).
interface bnn_param_loader_if #(
    parameter int unsigned BYTE_W = 8
);
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bnn_param_loader.sv
// Serializes host configuration bytes MSB-first into the neuron daisy chain,
// optionally comparing the chain tail against the re-sent stream.
module bnn_param_loader #(
    parameter int unsigned CHAIN_LEN = 44,
    parameter int unsigned BYTE_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              verify_en,
    bnn_param_loader_if.slave bus,
    output logic              setup,
    output logic              chain_data,
    input  logic              chain_tail,
    output logic              busy,
    output logic              done,
    output logic              mismatch
);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;

    state_t            state;
    logic [BYTE_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              verify_q;

    // chain_data is the bit on the wire this cycle; shift_q holds the bits still to follow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shift_q      <= '0;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            verify_q     <= 1'b0;
            bus.in_ready <= 1'b0;
            setup        <= 1'b0;
            chain_data   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= FETCH;
                        verify_q     <= verify_en;
                        mismatch     <= 1'b0;
                        bit_cnt      <= CNT_W'(CHAIN_LEN);
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.in_valid && bus.in_ready) begin
                        state        <= SHIFT;
                        chain_data   <= bus.in_data[BYTE_W-1];
                        shift_q      <= bus.in_data << 1;
                        bit_idx      <= IDX_W'(BYTE_W - 1);
                        bus.in_ready <= 1'b0;
                        setup        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (verify_q && (chain_tail != chain_data)) begin
                        mismatch <= 1'b1;
                    end
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                    // Partial final byte: the count runs out before bit_idx does.
                    if ((bit_cnt == '0) || (bit_cnt == CNT_W'(1))) begin
                        state      <= FINISH;
                        setup      <= 1'b0;
                        chain_data <= 1'b0;
                        done       <= 1'b1;
                    end else if (bit_idx == '0) begin
                        state        <= FETCH;
                        setup        <= 1'b0;
                        chain_data   <= 1'b0;
                        bus.in_ready <= 1'b1;
                    end else begin
                        chain_data <= shift_q[BYTE_W-1];
                        shift_q    <= shift_q << 1;
                        bit_idx    <= bit_idx - 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: a stream-level model of the expected bit
// sequence and chain contents, checked every cycle, plus literal anchors.
module tb_bnn_param_loader;
    localparam int unsigned L  = 44;
    localparam int unsigned L8 = 8;

    logic clk = 1'b0;
    logic reset, start, verify_en, setup, chain_data, chain_tail, busy, done, mismatch;
    logic start8, verify_en8, setup8, chain_data8, chain_tail8, busy8, done8, mismatch8;

    always #5 clk = ~clk;

    bnn_param_loader_if #(.BYTE_W(8)) bus  ();
    bnn_param_loader_if #(.BYTE_W(8)) bus8 ();

    bnn_param_loader #(.CHAIN_LEN(L), .BYTE_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .verify_en(verify_en), .bus(bus),
        .setup(setup), .chain_data(chain_data), .chain_tail(chain_tail),
        .busy(busy), .done(done), .mismatch(mismatch)
    );

    bnn_param_loader #(.CHAIN_LEN(L8), .BYTE_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .verify_en(verify_en8), .bus(bus8),
        .setup(setup8), .chain_data(chain_data8), .chain_tail(chain_tail8),
        .busy(busy8), .done(done8), .mismatch(mismatch8)
    );

    // Neuron chain stand-ins: shift while setup, tail is the last neuron's output.
    logic [L-1:0]  chain;
    logic [L8-1:0] chain8;
    always @(posedge clk) begin
        if (reset) chain <= '0;
        else if (setup) chain <= {chain[L-2:0], chain_data};
    end
    always @(posedge clk) begin
        if (reset) chain8 <= '0;
        else if (setup8) chain8 <= {chain8[L8-2:0], chain_data8};
    end
    assign chain_tail  = chain[L-1];
    assign chain_tail8 = chain8[L8-1];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Stream model: the first L bits of the MSB-first byte stream, in send order.
    logic [7:0] stim[$];
    logic       exp_bits[$];
    logic       model_verify;
    logic       mm_model;
    logic       eb;
    int         k, setup_cnt, busy_cnt, done_cnt;
    logic       track = 1'b0;

    always @(negedge clk) begin
        if (track) begin
            if (busy) busy_cnt++;
            if (bus.in_ready) chk("ready_only_in_fetch", {61'd0, setup, done, busy}, 64'd1);
            if (setup) begin
                eb = (k < exp_bits.size()) ? exp_bits[k] : 1'b0;
                if (k < exp_bits.size()) chk("chain_data", {63'd0, chain_data}, {63'd0, eb});
                else chk("setup_overrun", k, exp_bits.size());
                chk("mismatch_live", {63'd0, mismatch}, {63'd0, mm_model});
                if (model_verify && (chain_tail !== eb)) mm_model = 1'b1;
                k++;
                setup_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("setup_cycles", setup_cnt, L);
                chk("mismatch_at_done", {63'd0, mismatch}, {63'd0, mm_model});
            end
        end
    end

    task automatic load_pass(input logic v, input int gap_at, input int gap_len,
                             input int abort_at, input logic hold_start, input int exp_busy);
        int           idx;
        int           gap;
        logic         finished;
        logic         aborted;
        logic [L-1:0] exp_chain;
        exp_bits.delete();
        foreach (stim[i]) for (int b = 7; b >= 0; b--)
            if (exp_bits.size() < L) exp_bits.push_back(stim[i][b]);
        model_verify = v;
        mm_model = 1'b0;
        k = 0; setup_cnt = 0; busy_cnt = 0; done_cnt = 0;
        track = 1'b1;
        idx = 0; gap = gap_len; finished = 1'b0; aborted = 1'b0;
        @(negedge clk); #1;
        start = 1'b1; verify_en = v; bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk); #1;
            if (!hold_start) start = 1'b0;
            if (done) finished = 1'b1;
            if (abort_at > 0 && setup_cnt == abort_at) begin
                reset = 1'b1; aborted = 1'b1; finished = 1'b1; bus.in_valid = 1'b0;
            end
            if (!finished) begin
                if (idx == gap_at && gap > 0 && (gap < gap_len || bus.in_ready)) begin
                    bus.in_valid = 1'b0;
                    chk("gap_in_ready", {63'd0, bus.in_ready}, 64'd1);
                    chk("gap_setup", {63'd0, setup}, 64'd0);
                    gap--;
                end else begin
                    bus.in_valid = (idx < stim.size());
                    bus.in_data  = bus.in_valid ? stim[idx] : 8'($urandom);
                    if (bus.in_valid && bus.in_ready) idx++;
                end
            end
        end
        if (!finished) chk("pass_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        if (aborted) begin
            start = 1'b0;
            @(negedge clk); #1;
            chk("abort_setup", {63'd0, setup}, 64'd0);
            chk("abort_busy", {63'd0, busy}, 64'd0);
            chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("abort_done", {63'd0, done}, 64'd0);
            reset = 1'b0;
            repeat (5) @(negedge clk);
            #1 chk("abort_no_done", done_cnt, 0);
        end else begin
            if (hold_start) begin
                @(negedge clk); #1;
            end
            start = 1'b0;
            repeat (10) @(negedge clk);
            #1;
            chk("done_once", done_cnt, 1);
            chk("idle_after", {63'd0, busy}, 64'd0);
            chk("bytes_used", idx, (L + 7) / 8);
            if (exp_busy != 0) chk("busy_cycles", busy_cnt, exp_busy);
            for (int i = 0; i < L; i++) exp_chain[L-1-i] = exp_bits[i];
            chk("chain_contents", {20'd0, chain}, {20'd0, exp_chain});
        end
        track = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first, last, done_at, acc, s8, dcnt;
        reset = 1'b1; start = 1'b0; verify_en = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        start8 = 1'b0; verify_en8 = 1'b0; bus8.in_valid = 1'b0; bus8.in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_setup", {63'd0, setup}, 64'd0);
        chk("rst_chain_data", {63'd0, chain_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_mismatch", {63'd0, mismatch}, 64'd0);
        #1 reset = 1'b0;

        // Plain load, valid held high: 6 fetches + 44 shifts + 1 finish.
        stim = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h70};
        load_pass(1'b0, -1, 0, 0, 1'b0, 51);
        chk("lit_chain_load", {20'd0, chain}, {20'd0, 44'hA53CFF00817});

        // Five-cycle valid gap before the third byte.
        load_pass(1'b0, 2, 5, 0, 1'b0, 56);
        chk("lit_chain_gap", {20'd0, chain}, {20'd0, 44'hA53CFF00817});

        // Verify with identical stream.
        load_pass(1'b1, -1, 0, 0, 1'b0, 51);
        chk("lit_verify_ok", {63'd0, mismatch}, 64'd0);
        chk("lit_chain_verify", {20'd0, chain}, {20'd0, 44'hA53CFF00817});

        // Verify with byte 4 changed: first difference at stream bit 31.
        stim[3] = 8'h01;
        load_pass(1'b1, -1, 0, 0, 1'b0, 51);
        chk("lit_verify_bad", {63'd0, mismatch}, 64'd1);
        chk("lit_chain_bad", {20'd0, chain}, {20'd0, 44'hA53CFF01817});
        repeat (4) @(negedge clk);
        #1 chk("lit_mismatch_sticky", {63'd0, mismatch}, 64'd1);

        // Reset on the 20th shift cycle, then a full reload.
        stim[3] = 8'h00;
        load_pass(1'b0, -1, 0, 20, 1'b0, 0);
        load_pass(1'b0, -1, 0, 0, 1'b0, 51);
        chk("lit_chain_reload", {20'd0, chain}, {20'd0, 44'hA53CFF00817});

        // start held through the whole pass, still high during FINISH.
        load_pass(1'b0, -1, 0, 0, 1'b1, 51);

        // CHAIN_LEN = 8: one byte, eight contiguous setup cycles, done right after.
        first = -1; last = -1; done_at = -1; acc = 0; s8 = 0; dcnt = 0;
        @(negedge clk); #1;
        start8 = 1'b1; bus8.in_valid = 1'b1; bus8.in_data = 8'hC3;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            start8 = 1'b0;
            if (bus8.in_valid && bus8.in_ready) acc++;
            if (setup8) begin
                s8++;
                if (first < 0) first = c;
                last = c;
            end
            if (done8) begin
                dcnt++;
                done_at = c;
            end
        end
        bus8.in_valid = 1'b0;
        chk("len8_bytes", acc, 1);
        chk("len8_setup_cycles", s8, 8);
        chk("len8_contiguous", last - first, 7);
        chk("len8_done_after", done_at, last + 1);
        chk("len8_done_once", dcnt, 1);
        chk("len8_chain", {56'd0, chain8}, 64'hC3);
        chk("len8_mismatch", {63'd0, mismatch8}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
